// File: rtl/snn_timestep_scheduler.sv
// snn_timestep_scheduler: sequences one sample through an 8-neuron LIF layer.
// Each sample starts by clearing the layer. Each timestep vector is then driven
// for one cycle and followed by a settle window. The layer's output spikes are
// counted during the drive and settle cycles, and the winning neuron (lowest
// index on ties) is reported over a valid/ready interface.
module snn_timestep_scheduler #(
  parameter int NUM_NEURONS   = 8,
  parameter int NUM_STEPS     = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 5
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  output logic                           o_busy,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic [NUM_NEURONS-1:0]         i_in_spike,
  output logic [NUM_NEURONS-1:0]         o_layer_spike,
  output logic                           o_layer_reset_n,
  input  logic [NUM_NEURONS-1:0]         i_layer_out_spike,
  output logic [$clog2(NUM_STEPS)-1:0]   o_step_idx,
  output logic                           o_result_valid,
  input  logic                           i_result_ready,
  output logic [$clog2(NUM_NEURONS)-1:0] o_result_class,
  output logic [CNT_W-1:0]               o_result_count
);

  localparam int STEP_W  = $clog2(NUM_STEPS);
  localparam int CLASS_W = $clog2(NUM_NEURONS);
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);

  localparam logic [STEP_W-1:0]  LAST_STEP   = STEP_W'(NUM_STEPS - 1);
  localparam logic [SET_W-1:0]   LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CLASS_W-1:0] LAST_NEURON = CLASS_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FETCH  = 3'd2,
    S_DRIVE  = 3'd3,
    S_SETTLE = 3'd4,
    S_SCAN   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_in_ready;
  logic [NUM_NEURONS-1:0]   r_layer_spike;
  logic                     r_layer_reset_n;
  logic [STEP_W-1:0]        r_step_idx;
  logic [SET_W-1:0]         r_settle_cnt;
  logic [CLASS_W-1:0]       r_scan_idx;
  logic [CNT_W-1:0]         r_cnt [NUM_NEURONS];
  logic [CLASS_W-1:0]       r_best_class;
  logic [CNT_W-1:0]         r_best_count;
  logic                     r_result_valid;

  logic                     w_in_window;
  logic                     w_clear_now;
  logic [CNT_W-1:0]         w_scan_cnt;

  // Saturating +1 of a spike counter when its lane fired.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic b);
    if (b && (v != CNT_MAX)) begin
      sat_inc = v + CNT_W'(1);
    end else begin
      sat_inc = v;
    end
  endfunction

  assign w_in_window = (r_state == S_DRIVE) || (r_state == S_SETTLE);
  assign w_clear_now = (r_state == S_IDLE) && i_start;
  assign w_scan_cnt  = r_cnt[r_scan_idx];

  // Per-neuron spike counters: zeroed on entry to CLEAR, count only in the window.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_cnt[i] <= '0;
    end else if (w_clear_now) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_cnt[i] <= '0;
    end else if (w_in_window) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_cnt[i] <= sat_inc(r_cnt[i], i_layer_out_spike[i]);
    end
  end

  // Sample sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_busy          <= 1'b0;
      r_in_ready      <= 1'b0;
      r_layer_spike   <= '0;
      r_layer_reset_n <= 1'b0;
      r_step_idx      <= '0;
      r_settle_cnt    <= '0;
      r_scan_idx      <= '0;
      r_best_class    <= '0;
      r_best_count    <= '0;
      r_result_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state         <= S_CLEAR;
            r_busy          <= 1'b1;
            r_layer_reset_n <= 1'b0;
            r_step_idx      <= '0;
            r_settle_cnt    <= '0;
            r_scan_idx      <= '0;
            r_best_class    <= '0;
            r_best_count    <= '0;
          end else begin
            r_layer_reset_n <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_state         <= S_FETCH;
          r_layer_reset_n <= 1'b1;
          r_in_ready      <= 1'b1;
        end
        S_FETCH: begin
          if (i_in_valid) begin
            r_state       <= S_DRIVE;
            r_in_ready    <= 1'b0;
            r_layer_spike <= i_in_spike;
          end
        end
        S_DRIVE: begin
          r_state       <= S_SETTLE;
          r_layer_spike <= '0;
          r_settle_cnt  <= '0;
        end
        S_SETTLE: begin
          if (r_settle_cnt == LAST_SETTLE) begin
            if (r_step_idx == LAST_STEP) begin
              r_state    <= S_SCAN;
              r_scan_idx <= '0;
            end else begin
              r_state    <= S_FETCH;
              r_step_idx <= r_step_idx + STEP_W'(1);
              r_in_ready <= 1'b1;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + SET_W'(1);
          end
        end
        S_SCAN: begin
          // Strictly greater keeps the lowest index on ties.
          if (w_scan_cnt > r_best_count) begin
            r_best_class <= r_scan_idx;
            r_best_count <= w_scan_cnt;
          end
          if (r_scan_idx == LAST_NEURON) begin
            r_state        <= S_DONE;
            r_result_valid <= 1'b1;
          end else begin
            r_scan_idx <= r_scan_idx + CLASS_W'(1);
          end
        end
        S_DONE: begin
          if (i_result_ready) begin
            r_state        <= S_IDLE;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_busy         <= 1'b0;
          r_in_ready     <= 1'b0;
          r_layer_spike  <= '0;
          r_result_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_in_ready      = r_in_ready;
  assign o_layer_spike   = r_layer_spike;
  assign o_layer_reset_n = r_layer_reset_n;
  assign o_step_idx      = r_step_idx;
  assign o_result_valid  = r_result_valid;
  assign o_result_class  = r_best_class;
  assign o_result_count  = r_best_count;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// tb_snn_timestep_scheduler: the stimulus process drives samples and a layer
// model. It pushes the expected winner into a queue, and a separate monitor pops
// and compares the queue entry on every result handshake.
module tb_snn_timestep_scheduler;

  localparam int NN = 8;
  localparam int NS = 16;
  localparam int SC = 2;
  localparam int CW = 5;
  localparam int NOMINAL_LAT = 1 + NS * (2 + SC) + NN;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [NN-1:0] in_spike;
  logic [NN-1:0] layer_spike;
  logic          layer_reset_n;
  logic [NN-1:0] layer_out_spike;
  logic [3:0]    step_idx;
  logic          result_valid;
  logic          result_ready;
  logic [2:0]    result_class;
  logic [CW-1:0] result_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cls;
    int cnt;
  } res_t;
  res_t exp_q[$];

  snn_timestep_scheduler #(
    .NUM_NEURONS(NN), .NUM_STEPS(NS), .SETTLE_CYCLES(SC), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .o_busy(busy),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_spike(in_spike),
    .o_layer_spike(layer_spike), .o_layer_reset_n(layer_reset_n),
    .i_layer_out_spike(layer_out_spike), .o_step_idx(step_idx),
    .o_result_valid(result_valid), .i_result_ready(result_ready),
    .o_result_class(result_class), .o_result_count(result_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference classifier: saturate each total, then first index with the maximum.
  function automatic res_t ref_result(input int c[NN]);
    res_t r;
    int   sat_max;
    sat_max = (1 << CW) - 1;
    r.cls = 0;
    r.cnt = 0;
    for (int i = 0; i < NN; i++) begin
      int v;
      v = (c[i] > sat_max) ? sat_max : c[i];
      if (v > r.cnt) begin
        r.cls = i;
        r.cnt = v;
      end
    end
    return r;
  endfunction

  // Layer behaviour per test mode; win==SC+1 means the coming edge is the drive cycle.
  function automatic logic [NN-1:0] layer_gen(input int mode, input int win, input int step);
    logic [NN-1:0] v;
    v = '0;
    case (mode)
      1: if (win == SC + 1) begin
           v[5] = 1'b1;
           v[2] = (step % 2 == 0);
         end
      2: if (win == SC + 1) begin
           v[3] = (step < 9);
           v[6] = (step < 9);
           v[0] = (step < 8);
           v[7] = (step < 5);
         end
      3: v[1] = 1'b1;
      4: v = NN'($urandom);
      5: begin
           v[4] = (win == SC + 1);
           v[2] = (win == 0);
         end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Monitor: compare every handshaked result against the scoreboard queue.
  always @(negedge clk) begin
    res_t e;
    if (!reset && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got class %0d count %0d expected none", result_class, result_count);
      end else begin
        e = exp_q.pop_front();
        check("result_class", 32'(result_class), 32'(e.cls));
        check("result_count", 32'(result_count), 32'(e.cnt));
      end
    end
  end

  task automatic run_sample(input int mode, input int stall_step, input int stall_len,
                            input bit bubbles, input int rdy_delay, input bit start_in_done,
                            input bit abort);
    int            c[NN];
    int            hs_count, win, e, stalls, stall_left;
    bit            prev_hs, pushed, seen;
    logic [NN-1:0] prev_vec;
    int            cls0, cnt0;
    for (int i = 0; i < NN; i++) c[i] = 0;
    hs_count = 0; win = 0; stalls = 0; stall_left = stall_len;
    prev_hs = 0; pushed = 0; seen = 0; prev_vec = '0;
    @(posedge clk); #1;
    start = 1'b1;
    in_valid = 1'b0;
    result_ready = 1'b0;
    layer_out_spike = layer_gen(mode, 0, 0);
    e = -1;
    for (int it = 0; it < 1000; it++) begin
      @(posedge clk); #1;
      e++;
      start = 1'b0;
      check("layer_reset_n", 32'(layer_reset_n), (e == 0) ? 32'd0 : 32'd1);
      check("layer_spike", 32'(layer_spike), prev_hs ? 32'(prev_vec) : 32'd0);
      if (prev_hs) check("step_idx", 32'(step_idx), 32'(hs_count - 1));
      if (result_valid) begin
        seen = 1;
        break;
      end
      if (abort && hs_count == 8) begin
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_layer_spike", 32'(layer_spike), 32'd0);
        check("abort_step_idx", 32'(step_idx), 32'd0);
        check("abort_layer_reset_n", 32'(layer_reset_n), 32'd0);
        check("abort_result_valid", 32'(result_valid), 32'd0);
        check("abort_result_class", 32'(result_class), 32'd0);
        check("abort_result_count", 32'(result_count), 32'd0);
        in_valid = 1'b0;
        layer_out_spike = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_hold_layer_reset_n", 32'(layer_reset_n), 32'd0);
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          check("post_abort_busy", 32'(busy), 32'd0);
          check("post_abort_result_valid", 32'(result_valid), 32'd0);
          if (k == 0) check("post_abort_layer_reset_n", 32'(layer_reset_n), 32'd1);
        end
        return;
      end
      in_spike = (mode == 0) ? '0 : NN'($urandom);
      if (in_ready && hs_count == stall_step && stall_left > 0) begin
        in_valid = 1'b0;
        stall_left--;
      end else if (bubbles) begin
        in_valid = ($urandom % 3) != 0;
      end else begin
        in_valid = 1'b1;
      end
      if (in_ready && !in_valid) stalls++;
      layer_out_spike = layer_gen(mode, win, hs_count - 1);
      if (win > 0) begin
        for (int i = 0; i < NN; i++) c[i] += int'(layer_out_spike[i]);
        win--;
      end
      prev_hs = in_valid && in_ready;
      prev_vec = in_spike;
      if (prev_hs) begin
        hs_count++;
        win = SC + 1;
      end
      if (hs_count == NS && win == 0 && !pushed) begin
        exp_q.push_back(ref_result(c));
        pushed = 1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got no result_valid expected one within 1000 cycles");
      return;
    end
    check("latency", 32'(e), 32'(NOMINAL_LAT + stalls));
    cls0 = int'(result_class);
    cnt0 = int'(result_count);
    in_valid = 1'b0;
    layer_out_spike = '0;
    for (int k = 0; k < rdy_delay; k++) begin
      start = start_in_done && (k == 3);
      result_ready = 1'b0;
      @(posedge clk); #1;
      check("hold_result_valid", 32'(result_valid), 32'd1);
      check("hold_result_class", 32'(result_class), 32'(cls0));
      check("hold_result_count", 32'(result_count), 32'(cnt0));
      check("hold_busy", 32'(busy), 32'd1);
    end
    start = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("post_ack_result_valid", 32'(result_valid), 32'd0);
    check("post_ack_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("idle_stays_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_spike = '0;
    layer_out_spike = '0;
    result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_layer_spike", 32'(layer_spike), 32'd0);
    check("rst_step_idx", 32'(step_idx), 32'd0);
    check("rst_layer_reset_n", 32'(layer_reset_n), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_result_class", 32'(result_class), 32'd0);
    check("rst_result_count", 32'(result_count), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("release_layer_reset_n", 32'(layer_reset_n), 32'd1);
    check("release_busy", 32'(busy), 32'd0);

    run_sample(0, -1, 0, 1'b0, 0, 1'b0, 1'b0);   // silent layer
    run_sample(1, -1, 0, 1'b0, 0, 1'b0, 1'b0);   // argmax: neuron 5
    run_sample(2, -1, 0, 1'b0, 0, 1'b0, 1'b0);   // tie 3 vs 6
    run_sample(3, -1, 0, 1'b0, 0, 1'b0, 1'b0);   // saturation
    run_sample(5, -1, 0, 1'b0, 0, 1'b0, 1'b0);   // spikes outside window ignored
    run_sample(4, 4, 5, 1'b0, 10, 1'b1, 1'b0);   // backpressure + held result
    run_sample(4, -1, 0, 1'b0, 0, 1'b0, 1'b1);   // mid-sample reset
    for (int n = 0; n < 6; n++) begin
      run_sample(4, -1, 0, 1'b1, int'($urandom % 3), 1'b0, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
